// File: rtl/cm_cntr.sv
// cm_cntr: parametrised up/down counter with a programmable [min,max] window,
// multi-step arithmetic, runtime wrap/saturate selection, event pulses, an
// error pulse for illegal configurations, and a sticky event flag.
// All outputs come straight from registers.
module cm_cntr #(
  parameter int              W       = 8,
  parameter int              STEP_W  = 4,
  parameter logic [W-1:0]    RST_VAL = {W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [W-1:0]      i_load_val,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_mode,
  input  logic [W-1:0]      i_min,
  input  logic [W-1:0]      i_max,
  output logic [W-1:0]      o_cnt,
  output logic              o_wrap,
  output logic              o_sat,
  output logic              o_err,
  output logic              o_evt_sticky
);

  localparam logic [W-1:0] ONE_W = W'(1'b1);
  localparam logic [W:0]   ONE_X = (W+1)'(1'b1);

  logic [W-1:0] cnt_r;
  logic         wrap_r;
  logic         sat_r;
  logic         err_r;
  logic         sticky_r;

  logic [W-1:0] cnt_nxt_s;
  logic         wrap_nxt_s;
  logic         sat_nxt_s;
  logic         err_nxt_s;
  logic         sticky_nxt_s;

  // Widened operands: one extra bit so the full window (R = 2^W) and
  // cnt + step never overflow.
  logic [W-1:0] step_w_s;
  logic [W:0]   step_x_s;
  logic [W:0]   cnt_x_s;
  logic [W:0]   min_x_s;
  logic [W:0]   max_x_s;
  logic [W:0]   range_s;
  logic [W:0]   sum_s;
  logic [W:0]   floor_s;

  assign step_w_s = W'(i_step);
  assign step_x_s = {1'b0, step_w_s};
  assign cnt_x_s  = {1'b0, cnt_r};
  assign min_x_s  = {1'b0, i_min};
  assign max_x_s  = {1'b0, i_max};
  assign range_s  = max_x_s - min_x_s + ONE_X;
  assign sum_s    = cnt_x_s + step_x_s;
  assign floor_s  = min_x_s + step_x_s;

  // Next-state computation: clear > load > enabled step, with error checks
  // evaluated before any arithmetic on an enabled step.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    wrap_nxt_s   = 1'b0;
    sat_nxt_s    = 1'b0;
    err_nxt_s    = 1'b0;
    sticky_nxt_s = sticky_r;
    if (i_clr) begin
      cnt_nxt_s    = i_min;
      sticky_nxt_s = 1'b0;
    end else if (i_load) begin
      cnt_nxt_s = i_load_val;
    end else if (i_en) begin
      if (step_w_s == {W{1'b0}}) begin
        cnt_nxt_s = cnt_r;
      end else if (i_min > i_max) begin
        err_nxt_s = 1'b1;
      end else if (step_x_s > range_s) begin
        err_nxt_s = 1'b1;
      end else if (cnt_r < i_min) begin
        cnt_nxt_s = i_min;
        err_nxt_s = 1'b1;
      end else if (cnt_r > i_max) begin
        cnt_nxt_s = i_max;
        err_nxt_s = 1'b1;
      end else if (i_dir) begin
        if (sum_s <= max_x_s) begin
          cnt_nxt_s = sum_s[W-1:0];
        end else if (i_mode) begin
          cnt_nxt_s = i_max;
          sat_nxt_s = 1'b1;
        end else begin
          // True result lies inside the window, so modulo-2^W math is exact.
          cnt_nxt_s  = i_min + (sum_s[W-1:0] - i_max - ONE_W);
          wrap_nxt_s = 1'b1;
        end
      end else begin
        if (cnt_x_s >= floor_s) begin
          cnt_nxt_s = cnt_r - step_w_s;
        end else if (i_mode) begin
          cnt_nxt_s = i_min;
          sat_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s  = i_max - (i_min + step_w_s - cnt_r - ONE_W);
          wrap_nxt_s = 1'b1;
        end
      end
      sticky_nxt_s = sticky_r | wrap_nxt_s | sat_nxt_s;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and flag registers; reset aborts any pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= RST_VAL;
      wrap_r   <= 1'b0;
      sat_r    <= 1'b0;
      err_r    <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      wrap_r   <= wrap_nxt_s;
      sat_r    <= sat_nxt_s;
      err_r    <= err_nxt_s;
      sticky_r <= sticky_nxt_s;
    end
  end

  assign o_cnt        = cnt_r;
  assign o_wrap       = wrap_r;
  assign o_sat        = sat_r;
  assign o_err        = err_r;
  assign o_evt_sticky = sticky_r;

endmodule

// File: tb/tb_cm_cntr.sv
// Self-checking bench for cm_cntr (W=8, STEP_W=4, RST_VAL=0): a behavioural
// integer model pushes expected results into a queue as stimulus is driven;
// they are popped and compared one cycle later.
module tb_cm_cntr;

  logic       clk;
  logic       rst_n;
  logic       i_clr;
  logic       i_load;
  logic [7:0] i_load_val;
  logic       i_en;
  logic       i_dir;
  logic [3:0] i_step;
  logic       i_mode;
  logic [7:0] i_min;
  logic [7:0] i_max;
  logic [7:0] o_cnt;
  logic       o_wrap;
  logic       o_sat;
  logic       o_err;
  logic       o_evt_sticky;

  typedef struct packed {
    logic [7:0] cnt;
    logic       wrap;
    logic       sat;
    logic       err;
    logic       sticky;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   m_cnt;
  int   m_sticky;

  cm_cntr #(.W(8), .STEP_W(4), .RST_VAL(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_load(i_load),
    .i_load_val(i_load_val), .i_en(i_en), .i_dir(i_dir), .i_step(i_step),
    .i_mode(i_mode), .i_min(i_min), .i_max(i_max), .o_cnt(o_cnt),
    .o_wrap(o_wrap), .o_sat(o_sat), .o_err(o_err), .o_evt_sticky(o_evt_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, model, push, wait for the edge, pop and compare.
  task automatic drive(input logic clr, input logic ld, input logic [7:0] lv,
                       input logic en, input logic dir, input logic [3:0] st,
                       input logic md, input logic [7:0] mn, input logic [7:0] mx);
    exp_t e;
    int   w, s, er, stp, lo, hi;
    i_clr = clr; i_load = ld; i_load_val = lv; i_en = en; i_dir = dir;
    i_step = st; i_mode = md; i_min = mn; i_max = mx;
    w = 0; s = 0; er = 0; stp = int'(st); lo = int'(mn); hi = int'(mx);
    if (clr) begin
      m_cnt = lo; m_sticky = 0;
    end else if (ld) begin
      m_cnt = int'(lv);
    end else if (en) begin
      if (stp == 0) begin
        er = 0;
      end else if (lo > hi) begin
        er = 1;
      end else if (stp > hi - lo + 1) begin
        er = 1;
      end else if (m_cnt < lo) begin
        m_cnt = lo; er = 1;
      end else if (m_cnt > hi) begin
        m_cnt = hi; er = 1;
      end else if (dir) begin
        if (m_cnt + stp <= hi) m_cnt = m_cnt + stp;
        else if (md) begin m_cnt = hi; s = 1; end
        else begin m_cnt = lo + (m_cnt + stp - hi - 1); w = 1; end
      end else begin
        if (m_cnt >= lo + stp) m_cnt = m_cnt - stp;
        else if (md) begin m_cnt = lo; s = 1; end
        else begin m_cnt = hi - (lo + stp - m_cnt - 1); w = 1; end
      end
      if (w == 1 || s == 1) m_sticky = 1;
    end
    e.cnt = 8'(m_cnt); e.wrap = (w == 1); e.sat = (s == 1);
    e.err = (er == 1); e.sticky = (m_sticky == 1);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("cnt", 32'(o_cnt), 32'(e.cnt));
      chk("wrap", 32'(o_wrap), 32'(e.wrap));
      chk("sat", 32'(o_sat), 32'(e.sat));
      chk("err", 32'(o_err), 32'(e.err));
      chk("sticky", 32'(o_evt_sticky), 32'(e.sticky));
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_cnt = 0; m_sticky = 0;
    rst_n = 1'b0; i_clr = 1'b0; i_load = 1'b0; i_load_val = 8'd0; i_en = 1'b0;
    i_dir = 1'b0; i_step = 4'd0; i_mode = 1'b0; i_min = 8'd0; i_max = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    chk("rst_flags", 32'({o_wrap, o_sat, o_err, o_evt_sticky}), 32'd0);
    rst_n = 1'b1;

    // Plan 1: wrap up, window 3..7, step 2, load 6 -> 3,5,7,4
    drive(1'b0, 1'b1, 8'd6, 1'b0, 1'b1, 4'd2, 1'b0, 8'd3, 8'd7);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd3, 8'd7);
    chk("p1_a", 32'({o_cnt, o_wrap}), 32'({8'd3, 1'b1}));
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd3, 8'd7);
    chk("p1_b", 32'({o_cnt, o_wrap}), 32'({8'd5, 1'b0}));
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd3, 8'd7);
    chk("p1_c", 32'({o_cnt, o_wrap}), 32'({8'd7, 1'b0}));
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd3, 8'd7);
    chk("p1_d", 32'({o_cnt, o_wrap, o_evt_sticky}), 32'({8'd4, 1'b1, 1'b1}));

    // Plan 2: saturate down, window 10..20, step 4, load 13 -> 10,10,10
    drive(1'b0, 1'b1, 8'd13, 1'b0, 1'b0, 4'd4, 1'b1, 8'd10, 8'd20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'd4, 1'b1, 8'd10, 8'd20);
      chk("p2", 32'({o_cnt, o_sat, o_wrap}), 32'({8'd10, 1'b1, 1'b0}));
    end

    // Plan 3: full window wrap 255 -> 0
    drive(1'b0, 1'b1, 8'd255, 1'b0, 1'b1, 4'd1, 1'b0, 8'd0, 8'd255);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0, 8'd255);
    chk("p3", 32'({o_cnt, o_wrap, o_err}), 32'({8'd0, 1'b1, 1'b0}));
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd15, 1'b1, 8'd0, 8'd255);

    // Plan 4: error cases
    drive(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 4'd5, 1'b0, 8'd2, 8'd4);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd5, 1'b0, 8'd2, 8'd4);
    chk("p4_step", 32'({o_cnt, o_err}), 32'({8'd3, 1'b1}));
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd1, 1'b0, 8'd9, 8'd4);
    chk("p4_minmax", 32'({o_cnt, o_err}), 32'({8'd3, 1'b1}));
    drive(1'b0, 1'b1, 8'd50, 1'b0, 1'b1, 4'd1, 1'b1, 8'd0, 8'd20);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd1, 1'b1, 8'd0, 8'd20);
    chk("p4_clamp", 32'({o_cnt, o_err, o_sat}), 32'({8'd20, 1'b1, 1'b0}));
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 8'd20);

    // Plan 5: priority
    drive(1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 4'd1, 1'b0, 8'd1, 8'd20);
    chk("p5_clr", 32'({o_cnt, o_evt_sticky}), 32'({8'd1, 1'b0}));
    drive(1'b0, 1'b1, 8'd9, 1'b1, 1'b1, 4'd1, 1'b0, 8'd1, 8'd20);
    chk("p5_load", 32'(o_cnt), 32'd9);

    // Plan 6: count to 5 with a wrap on the way, then reset mid-cycle
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 4'd1, 1'b0, 8'd0, 8'd7);
    drive(1'b0, 1'b1, 8'd6, 1'b0, 1'b1, 4'd1, 1'b0, 8'd0, 8'd7);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd3, 1'b0, 8'd0, 8'd7);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd0, 8'd7);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd0, 8'd7);
    chk("p6_pre", 32'({o_cnt, o_evt_sticky}), 32'({8'd5, 1'b1}));
    i_step = 4'd1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("p6_rst", 32'({o_cnt, o_wrap, o_sat, o_err, o_evt_sticky}), 32'd0);
    m_cnt = 0; m_sticky = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0, 8'd7);
    chk("p6_post", 32'(o_cnt), 32'd1);

    // Random traffic through the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] mn, mx, tmp;
      mn = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        tmp = 8'($urandom_range(0, 20));
        mx = (int'(mn) + int'(tmp) > 255) ? 8'd255 : mn + tmp;
      end else begin
        mx = 8'($urandom_range(0, 255));
      end
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), mn, mx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
